// File: rtl/mem_burst_arbiter.sv
// ---------------------------------------------------------------------------
// mem_burst_arbiter
//   Shares one external-memory burst user interface between NUM_CH clients.
//   Clients present a unified command (req/we/len/addr). A round-robin
//   arbiter picks one client at a time. The block forwards that client's
//   command to the rd_* or wr_* memory request, routes the data handshakes
//   to it, and returns the burst-finish pulse to the same client.
//
// Ports
//   mem_clk, rst_n          : clock; synchronous active-low reset
//   ch_req/we/len/addr      : per-channel command; channel i at [i*W +: W]
//   ch_wr_data              : per-channel write data, packed like ch_len
//   ch_wr_data_req          : write-data request to the granted channel
//   ch_rd_data_valid        : read-data valid to the granted channel
//   ch_rd_data              : read data, broadcast to every channel
//   ch_finish               : one-cycle burst-complete pulse to the granted channel
//   grant                   : one-hot current grant; 0 when idle
//   rd_/wr_burst_req/len/addr : burst command to the memory controller
//   rd_burst_data_valid, rd_burst_data, rd_burst_finish : read side from controller
//   wr_burst_data_req, wr_burst_data, wr_burst_finish   : write side to/from controller
// ---------------------------------------------------------------------------
module mem_burst_arbiter #(
  parameter int NUM_CH        = 2,
  parameter int MEM_DATA_BITS = 32,
  parameter int ADDR_BITS     = 23,
  parameter int BURST_BITS    = 10
) (
  input  logic                            mem_clk,
  input  logic                            rst_n,
  input  logic [NUM_CH-1:0]               ch_req,
  input  logic [NUM_CH-1:0]               ch_we,
  input  logic [NUM_CH*BURST_BITS-1:0]    ch_len,
  input  logic [NUM_CH*ADDR_BITS-1:0]     ch_addr,
  input  logic [NUM_CH*MEM_DATA_BITS-1:0] ch_wr_data,
  output logic [NUM_CH-1:0]               ch_wr_data_req,
  output logic [NUM_CH-1:0]               ch_rd_data_valid,
  output logic [MEM_DATA_BITS-1:0]        ch_rd_data,
  output logic [NUM_CH-1:0]               ch_finish,
  output logic [NUM_CH-1:0]               grant,
  output logic                            rd_burst_req,
  output logic                            wr_burst_req,
  output logic [BURST_BITS-1:0]           rd_burst_len,
  output logic [BURST_BITS-1:0]           wr_burst_len,
  output logic [ADDR_BITS-1:0]            rd_burst_addr,
  output logic [ADDR_BITS-1:0]            wr_burst_addr,
  input  logic                            rd_burst_data_valid,
  input  logic                            wr_burst_data_req,
  input  logic [MEM_DATA_BITS-1:0]        rd_burst_data,
  output logic [MEM_DATA_BITS-1:0]        wr_burst_data,
  input  logic                            rd_burst_finish,
  input  logic                            wr_burst_finish
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_ZLEN  = 2'd3;

  // Pointer reset value makes channel 0 the first winner after reset.
  localparam logic [CH_W-1:0] LAST_RST = CH_W'(NUM_CH - 1);

  // Unpacked per-channel views of the packed command buses.
  logic [BURST_BITS-1:0]    len_a   [NUM_CH];
  logic [ADDR_BITS-1:0]     addr_a  [NUM_CH];
  logic [MEM_DATA_BITS-1:0] wdata_a [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign len_a[i]   = ch_len[i*BURST_BITS +: BURST_BITS];
    assign addr_a[i]  = ch_addr[i*ADDR_BITS +: ADDR_BITS];
    assign wdata_a[i] = ch_wr_data[i*MEM_DATA_BITS +: MEM_DATA_BITS];
  end

  logic [1:0]            state_q, state_d;
  logic [NUM_CH-1:0]     grant_q, grant_d;
  logic [CH_W-1:0]       gnt_idx_q, gnt_idx_d;
  logic [CH_W-1:0]       last_q, last_d;
  logic                  rd_req_q, rd_req_d, wr_req_q, wr_req_d;
  logic [BURST_BITS-1:0] rd_len_q, rd_len_d, wr_len_q, wr_len_d;
  logic [ADDR_BITS-1:0]  rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;

  // Round-robin winner: first requester scanning cyclically from last+1.
  logic            win_found;
  logic [CH_W-1:0] win_idx;
  logic [CH_W-1:0] cand;

  // NOTE: every variable driven in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(last_q) + k) % NUM_CH);
      if (!win_found && ch_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gnt_idx_d = gnt_idx_q;
    last_d    = last_q;
    rd_req_d  = rd_req_q;
    wr_req_d  = wr_req_q;
    rd_len_d  = rd_len_q;
    wr_len_d  = wr_len_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          gnt_idx_d        = win_idx;
          last_d           = win_idx;
          if (len_a[win_idx] == '0) begin
            // Zero-length burst: complete locally, never bother the controller.
            state_d = ST_ZLEN;
          end else if (ch_we[win_idx]) begin
            state_d   = ST_WRITE;
            wr_req_d  = 1'b1;
            wr_len_d  = len_a[win_idx];
            wr_addr_d = addr_a[win_idx];
          end else begin
            state_d   = ST_READ;
            rd_req_d  = 1'b1;
            rd_len_d  = len_a[win_idx];
            rd_addr_d = addr_a[win_idx];
          end
        end
      end
      ST_WRITE: begin
        if (wr_burst_finish) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          wr_req_d = 1'b0;
        end else if (wr_burst_data_req) begin
          // The controller has accepted the command once it asks for data.
          wr_req_d = 1'b0;
        end
      end
      ST_READ: begin
        if (rd_burst_finish) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rd_req_d = 1'b0;
        end else if (rd_burst_data_valid) begin
          rd_req_d = 1'b0;
        end
      end
      default: begin // ST_ZLEN
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      gnt_idx_q <= '0;
      last_q    <= LAST_RST;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      rd_len_q  <= '0;
      wr_len_q  <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gnt_idx_q <= gnt_idx_d;
      last_q    <= last_d;
      rd_req_q  <= rd_req_d;
      wr_req_q  <= wr_req_d;
      rd_len_q  <= rd_len_d;
      wr_len_q  <= wr_len_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  // Data-path routing; grant_q is one-hot, so masking with it selects the client.
  assign ch_wr_data_req   = (state_q == ST_WRITE) ? (grant_q & {NUM_CH{wr_burst_data_req}})   : '0;
  assign ch_rd_data_valid = (state_q == ST_READ)  ? (grant_q & {NUM_CH{rd_burst_data_valid}}) : '0;
  assign ch_rd_data       = rd_burst_data;
  assign wr_burst_data    = (state_q == ST_WRITE) ? wdata_a[gnt_idx_q] : '0;

  always_comb begin
    ch_finish = '0;
    case (state_q)
      ST_WRITE: ch_finish = grant_q & {NUM_CH{wr_burst_finish}};
      ST_READ:  ch_finish = grant_q & {NUM_CH{rd_burst_finish}};
      ST_ZLEN:  ch_finish = grant_q;
      default:  ch_finish = '0;
    endcase
  end

  assign grant         = grant_q;
  assign rd_burst_req  = rd_req_q;
  assign wr_burst_req  = wr_req_q;
  assign rd_burst_len  = rd_len_q;
  assign wr_burst_len  = wr_len_q;
  assign rd_burst_addr = rd_addr_q;
  assign wr_burst_addr = wr_addr_q;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_burst_arbiter
//   Directed bench for mem_burst_arbiter with NUM_CH=2. Inputs change 1 ns
//   after the rising edge; outputs are sampled 1-2 ns after the edge.
// ---------------------------------------------------------------------------
module tb_mem_burst_arbiter;

  localparam int NCH = 2;
  localparam int DW  = 32;
  localparam int AW  = 23;
  localparam int BW  = 10;

  logic              mem_clk = 1'b0;
  logic              rst_n   = 1'b0;
  logic [NCH-1:0]    ch_req  = '0;
  logic [NCH-1:0]    ch_we   = '0;
  logic [NCH*BW-1:0] ch_len  = '0;
  logic [NCH*AW-1:0] ch_addr = '0;
  logic [NCH*DW-1:0] ch_wr_data = '0;
  logic [NCH-1:0]    ch_wr_data_req, ch_rd_data_valid, ch_finish, grant;
  logic [DW-1:0]     ch_rd_data;
  logic              rd_burst_req, wr_burst_req;
  logic [BW-1:0]     rd_burst_len, wr_burst_len;
  logic [AW-1:0]     rd_burst_addr, wr_burst_addr;
  logic              rd_burst_data_valid = 1'b0;
  logic              wr_burst_data_req   = 1'b0;
  logic [DW-1:0]     rd_burst_data       = '0;
  logic [DW-1:0]     wr_burst_data;
  logic              rd_burst_finish = 1'b0;
  logic              wr_burst_finish = 1'b0;

  int passed = 0;
  int total  = 0;

  mem_burst_arbiter #(.NUM_CH(NCH), .MEM_DATA_BITS(DW), .ADDR_BITS(AW), .BURST_BITS(BW)) dut (
    .mem_clk(mem_clk), .rst_n(rst_n),
    .ch_req(ch_req), .ch_we(ch_we), .ch_len(ch_len), .ch_addr(ch_addr), .ch_wr_data(ch_wr_data),
    .ch_wr_data_req(ch_wr_data_req), .ch_rd_data_valid(ch_rd_data_valid), .ch_rd_data(ch_rd_data),
    .ch_finish(ch_finish), .grant(grant),
    .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
    .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
    .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid), .wr_burst_data_req(wr_burst_data_req),
    .rd_burst_data(rd_burst_data), .wr_burst_data(wr_burst_data),
    .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish)
  );

  always #5 mem_clk = ~mem_clk;

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_ch(input int idx, input logic req, input logic we,
                        input logic [BW-1:0] len, input logic [AW-1:0] addr);
    ch_req[idx]           = req;
    ch_we[idx]            = we;
    ch_len[idx*BW +: BW]  = len;
    ch_addr[idx*AW +: AW] = addr;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (grant !== 2'b00) $display("FAIL rst_grant: got %b exp 00", grant); else passed++;
    total++; if ({rd_burst_req, wr_burst_req} !== 2'b00) $display("FAIL rst_req: got %b exp 00", {rd_burst_req, wr_burst_req}); else passed++;
    total++; if ({rd_burst_len, wr_burst_len, rd_burst_addr, wr_burst_addr} !== '0) $display("FAIL rst_len_addr: got nonzero %h", {rd_burst_len, wr_burst_len, rd_burst_addr, wr_burst_addr}); else passed++;
    // Controller strobes while idle must not reach any client.
    wr_burst_data_req = 1'b1; rd_burst_data_valid = 1'b1; wr_burst_finish = 1'b1; rd_burst_finish = 1'b1;
    #1;
    total++; if ({ch_finish, ch_wr_data_req, ch_rd_data_valid} !== 6'b0) $display("FAIL idle_strobes: got %b exp 000000", {ch_finish, ch_wr_data_req, ch_rd_data_valid}); else passed++;
    total++; if (wr_burst_data !== 32'h0) $display("FAIL idle_wdata: got %h exp 0", wr_burst_data); else passed++;
    tick();
    wr_burst_data_req = 1'b0; rd_burst_data_valid = 1'b0; wr_burst_finish = 1'b0; rd_burst_finish = 1'b0;
    total++; if (grant !== 2'b00) $display("FAIL idle_no_change: got %b exp 00", grant); else passed++;
  endtask

  task automatic test_write();
    int pulses = 0;
    int bad_other = 0;
    set_ch(0, 1'b1, 1'b1, 10'd4, 23'h100);
    ch_wr_data[DW +: DW] = 32'hDEAD_BEEF;
    ch_wr_data[0 +: DW]  = 32'h0000_1000;
    #1;
    total++; if ({grant, wr_burst_req} !== 3'b000) $display("FAIL wr_latency: got %b exp 000", {grant, wr_burst_req}); else passed++;
    tick();
    total++; if (grant !== 2'b01) $display("FAIL wr_grant: got %b exp 01", grant); else passed++;
    total++; if ({wr_burst_req, rd_burst_req} !== 2'b10) $display("FAIL wr_req: got %b exp 10", {wr_burst_req, rd_burst_req}); else passed++;
    total++; if (wr_burst_addr !== 23'h100) $display("FAIL wr_addr: got %h exp 100", wr_burst_addr); else passed++;
    total++; if (wr_burst_len !== 10'd4) $display("FAIL wr_len: got %0d exp 4", wr_burst_len); else passed++;
    for (int i = 0; i < 4; i++) begin
      ch_wr_data[0 +: DW] = 32'h0000_1000 + 32'(i);
      wr_burst_data_req = 1'b1;
      #1;
      if (ch_wr_data_req[0]) pulses++;
      if (ch_wr_data_req[1]) bad_other++;
      total++; if (wr_burst_data !== 32'h0000_1000 + 32'(i)) $display("FAIL wr_data_beat%0d: got %h exp %h", i, wr_burst_data, 32'h0000_1000 + 32'(i)); else passed++;
      tick();
      wr_burst_data_req = 1'b0;
      tick();
    end
    total++; if (pulses !== 4) $display("FAIL wr_data_req_pulses: got %0d exp 4", pulses); else passed++;
    total++; if (bad_other !== 0) $display("FAIL wr_data_req_ch1: got %0d exp 0", bad_other); else passed++;
    total++; if (wr_burst_req !== 1'b0) $display("FAIL wr_req_drop: got %b exp 0", wr_burst_req); else passed++;
    set_ch(0, 1'b0, 1'b1, 10'd4, 23'h100);
    wr_burst_finish = 1'b1;
    #1;
    total++; if (ch_finish !== 2'b01) $display("FAIL wr_finish: got %b exp 01", ch_finish); else passed++;
    tick();
    wr_burst_finish = 1'b0;
    total++; if ({grant, ch_finish} !== 4'b0000) $display("FAIL wr_done_idle: got %b exp 0000", {grant, ch_finish}); else passed++;
    total++; if (wr_burst_data !== 32'h0) $display("FAIL wr_data_idle: got %h exp 0", wr_burst_data); else passed++;
  endtask

  task automatic test_read();
    int pulses = 0;
    int bad_other = 0;
    set_ch(1, 1'b1, 1'b0, 10'd8, 23'h2000);
    tick();
    total++; if (grant !== 2'b10) $display("FAIL rd_grant: got %b exp 10", grant); else passed++;
    total++; if ({rd_burst_req, wr_burst_req} !== 2'b10) $display("FAIL rd_req: got %b exp 10", {rd_burst_req, wr_burst_req}); else passed++;
    total++; if ({rd_burst_addr, rd_burst_len} !== {23'h2000, 10'd8}) $display("FAIL rd_cmd: got %h/%0d exp 2000/8", rd_burst_addr, rd_burst_len); else passed++;
    tick();
    total++; if (rd_burst_req !== 1'b1) $display("FAIL rd_req_hold: got %b exp 1", rd_burst_req); else passed++;
    for (int i = 0; i < 8; i++) begin
      rd_burst_data_valid = 1'b1;
      rd_burst_data = 32'hC0DE_0000 + 32'(i * 3);
      #1;
      if (ch_rd_data_valid[1]) pulses++;
      if (ch_rd_data_valid[0]) bad_other++;
      total++; if (ch_rd_data !== 32'hC0DE_0000 + 32'(i * 3)) $display("FAIL rd_data_beat%0d: got %h exp %h", i, ch_rd_data, 32'hC0DE_0000 + 32'(i * 3)); else passed++;
      tick();
      rd_burst_data_valid = 1'b0;
      if (i == 3) tick();
    end
    total++; if (pulses !== 8) $display("FAIL rd_valid_pulses: got %0d exp 8", pulses); else passed++;
    total++; if (bad_other !== 0) $display("FAIL rd_valid_ch0: got %0d exp 0", bad_other); else passed++;
    total++; if (rd_burst_req !== 1'b0) $display("FAIL rd_req_drop: got %b exp 0", rd_burst_req); else passed++;
    set_ch(1, 1'b0, 1'b0, 10'd8, 23'h2000);
    rd_burst_finish = 1'b1;
    #1;
    total++; if (ch_finish !== 2'b10) $display("FAIL rd_finish: got %b exp 10", ch_finish); else passed++;
    tick();
    rd_burst_finish = 1'b0;
    total++; if ({grant, ch_finish} !== 4'b0000) $display("FAIL rd_done_idle: got %b exp 0000", {grant, ch_finish}); else passed++;
  endtask

  task automatic test_ignore();
    set_ch(1, 1'b1, 1'b0, 10'd2, 23'h80);
    rd_burst_finish = 1'b1;
    #1;
    total++; if (ch_finish !== 2'b00) $display("FAIL ign_idle_finish: got %b exp 00", ch_finish); else passed++;
    tick();
    rd_burst_finish = 1'b0;
    total++; if ({grant, rd_burst_req} !== 3'b101) $display("FAIL ign_grant: got %b exp 101", {grant, rd_burst_req}); else passed++;
    wr_burst_finish = 1'b1; wr_burst_data_req = 1'b1;
    #1;
    total++; if ({ch_finish, ch_wr_data_req} !== 4'b0000) $display("FAIL ign_wr_in_read: got %b exp 0000", {ch_finish, ch_wr_data_req}); else passed++;
    tick();
    wr_burst_finish = 1'b0; wr_burst_data_req = 1'b0;
    total++; if ({grant, rd_burst_req} !== 3'b101) $display("FAIL ign_still_read: got %b exp 101", {grant, rd_burst_req}); else passed++;
    rd_burst_data_valid = 1'b1;
    tick();
    tick();
    rd_burst_data_valid = 1'b0;
    set_ch(1, 1'b0, 1'b0, 10'd2, 23'h80);
    rd_burst_finish = 1'b1;
    #1;
    total++; if (ch_finish !== 2'b10) $display("FAIL ign_rd_finish: got %b exp 10", ch_finish); else passed++;
    tick();
    rd_burst_finish = 1'b0;
    total++; if (grant !== 2'b00) $display("FAIL ign_done: got %b exp 00", grant); else passed++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    int n;
    set_ch(0, 1'b1, 1'b1, 10'd2, 23'h10);
    set_ch(1, 1'b1, 1'b0, 10'd2, 23'h20);
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      while (grant === 2'b00 && n < 4) begin
        tick();
        n++;
      end
      total++; if (grant !== exp_g) $display("FAIL rr_grant%0d: got %b exp %b (waited %0d)", k, grant, exp_g, n); else passed++;
      if (exp_g == 2'b01) wr_burst_finish = 1'b1;
      else                rd_burst_finish = 1'b1;
      #1;
      total++; if (ch_finish !== exp_g) $display("FAIL rr_finish%0d: got %b exp %b", k, ch_finish, exp_g); else passed++;
      tick();
      wr_burst_finish = 1'b0; rd_burst_finish = 1'b0;
      total++; if (grant !== 2'b00) $display("FAIL rr_idle_gap%0d: got %b exp 00", k, grant); else passed++;
    end
    ch_req = '0;
    tick();
  endtask

  task automatic test_zero_len();
    set_ch(0, 1'b1, 1'b1, 10'd0, 23'h0);
    set_ch(1, 1'b1, 1'b0, 10'd3, 23'h40);
    apply_reset();
    tick();
    total++; if ({grant, ch_finish} !== 4'b0101) $display("FAIL zl_grant_finish: got %b exp 0101", {grant, ch_finish}); else passed++;
    total++; if ({rd_burst_req, wr_burst_req} !== 2'b00) $display("FAIL zl_no_req: got %b exp 00", {rd_burst_req, wr_burst_req}); else passed++;
    ch_req[0] = 1'b0;
    tick();
    total++; if ({grant, ch_finish, rd_burst_req, wr_burst_req} !== 6'b0) $display("FAIL zl_idle: got %b exp 000000", {grant, ch_finish, rd_burst_req, wr_burst_req}); else passed++;
    tick();
    total++; if ({grant, rd_burst_req} !== 3'b101) $display("FAIL zl_next_ch1: got %b exp 101", {grant, rd_burst_req}); else passed++;
    total++; if ({rd_burst_addr, rd_burst_len} !== {23'h40, 10'd3}) $display("FAIL zl_ch1_cmd: got %h/%0d exp 40/3", rd_burst_addr, rd_burst_len); else passed++;
    ch_req = '0;
    rd_burst_finish = 1'b1;
    tick();
    rd_burst_finish = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    set_ch(0, 1'b1, 1'b0, 10'd6, 23'h300);
    set_ch(1, 1'b1, 1'b1, 10'd2, 23'h500);
    apply_reset();
    tick();
    total++; if ({grant, rd_burst_req} !== 3'b011) $display("FAIL rm_grant: got %b exp 011", {grant, rd_burst_req}); else passed++;
    rd_burst_data_valid = 1'b1;
    tick(); tick(); tick();
    rd_burst_data_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rd_burst_data_valid = 1'b1;
    #1;
    total++; if ({grant, rd_burst_req, wr_burst_req} !== 4'b0000) $display("FAIL rm_abort: got %b exp 0000", {grant, rd_burst_req, wr_burst_req}); else passed++;
    total++; if ({rd_burst_len, rd_burst_addr} !== '0) $display("FAIL rm_cmd_clr: got %h exp 0", {rd_burst_len, rd_burst_addr}); else passed++;
    total++; if ({ch_finish, ch_rd_data_valid} !== 4'b0000) $display("FAIL rm_no_finish: got %b exp 0000", {ch_finish, ch_rd_data_valid}); else passed++;
    rd_burst_data_valid = 1'b0;
    ch_req[0] = 1'b0;
    rst_n = 1'b1;
    tick();
    total++; if ({grant, wr_burst_req} !== 3'b101) $display("FAIL rm_ch1_after: got %b exp 101", {grant, wr_burst_req}); else passed++;
    total++; if (wr_burst_addr !== 23'h500) $display("FAIL rm_ch1_addr: got %h exp 500", wr_burst_addr); else passed++;
    wr_burst_finish = 1'b1;
    tick();
    wr_burst_finish = 1'b0;
    // Both requesting across a reset: pointer reset makes ch0 win.
    ch_req = 2'b11;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (grant !== 2'b01) $display("FAIL rm_ptr_reset: got %b exp 01", grant); else passed++;
    ch_req = '0;
    rd_burst_finish = 1'b1;
    tick();
    rd_burst_finish = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ignore();
    test_round_robin();
    test_zero_len();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
